ahb_arbiter_rr: RTL and testbench



---
 rtl/ahb_arbiter_rr.sv | 204 ++++++++++++++++++++
 tb/tb_ahb_arbiter_rr.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter_rr.sv
// AHB bus arbiter for NO_OF_MASTERS masters. It supports fixed-priority or round-robin arbitration and is burst-, lock- and SPLIT-aware.
// Optional feature macro AHB_ARB_SPLIT_EN builds SPLIT masking. Without it, SPLIT is handled exactly like RETRY.
module ahb_arbiter_rr #(
  parameter  int NO_OF_MASTERS  = 4,
  parameter  int DEFAULT_MASTER = 0,
  parameter  int ARB_MODE       = 1,
  localparam int MW             = $clog2(NO_OF_MASTERS)
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [NO_OF_MASTERS-1:0] HBUSREQ,
  input  logic [NO_OF_MASTERS-1:0] HLOCK,
  input  logic [NO_OF_MASTERS-1:0] HSPLIT,
  input  logic [1:0]               HTRANS,
  input  logic [2:0]               HBURST,
  input  logic                     HREADY,
  input  logic [1:0]               HRESP,
  output logic [NO_OF_MASTERS-1:0] HGRANT,
  output logic [MW-1:0]            HMASTER,
  output logic                     HMASTLOCK
);

  localparam int            N          = NO_OF_MASTERS;
  localparam logic [MW-1:0] DEF_IDX    = MW'(DEFAULT_MASTER);
  localparam logic [N-1:0]  DEF_ONEHOT = N'(1) << DEFAULT_MASTER;

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    BU_SINGLE = 3'b000,
    BU_INCR   = 3'b001,
    BU_WRAP4  = 3'b010,
    BU_INCR4  = 3'b011,
    BU_WRAP8  = 3'b100,
    BU_INCR8  = 3'b101,
    BU_WRAP16 = 3'b110,
    BU_INCR16 = 3'b111
  } hburst_e;

  typedef enum logic [1:0] {
    RS_OKAY  = 2'b00,
    RS_ERROR = 2'b01,
    RS_RETRY = 2'b10,
    RS_SPLIT = 2'b11
  } hresp_e;

  typedef enum logic [1:0] {
    ST_PARK,
    ST_OWNED,
    ST_LOCKED
  } state_e;

  state_e        state_q, state_d;
  logic [MW-1:0] grant_idx_q, grant_idx_d;
  logic [N-1:0]  hgrant_q, hgrant_d;
  logic [MW-1:0] hmaster_q, hmaster_d;
  logic          hmastlock_q, hmastlock_d;
  logic [3:0]    beat_cnt_q, beat_cnt_d;
  logic [MW-1:0] last_q, last_d;
  logic [N-1:0]  split_mask_d;

  logic          arb_point;
  logic          resp_abort;
  logic          lock_hold;
  logic [N-1:0]  eligible;
  logic [MW-1:0] winner;

  // Remaining beats after the NONSEQ beat of a fixed-length burst.
  function automatic logic [3:0] burst_beats(input logic [2:0] burst);
    logic [3:0] beats;
    case (burst)
      BU_WRAP4,  BU_INCR4:  beats = 4'd3;
      BU_WRAP8,  BU_INCR8:  beats = 4'd7;
      BU_WRAP16, BU_INCR16: beats = 4'd15;
      default:              beats = 4'd0;
    endcase
    return beats;
  endfunction

  function automatic logic [MW-1:0] fixed_pick(input logic [N-1:0] elig);
    logic [MW-1:0] pick;
    pick = DEF_IDX;
    for (int i = N - 1; i >= 0; i--) begin
      if (elig[MW'(i)]) pick = MW'(i);
    end
    return pick;
  endfunction

  // Scan downwards from last+N to last+1, so the index closest after last wins.
  function automatic logic [MW-1:0] rr_pick(input logic [N-1:0] elig, input logic [MW-1:0] last);
    logic [MW-1:0] pick;
    logic [MW-1:0] idx;
    pick = DEF_IDX;
    for (int k = N; k >= 1; k--) begin
      idx = MW'((int'(last) + k) % N);
      if (elig[idx]) pick = idx;
    end
    return pick;
  endfunction

`ifdef AHB_ARB_SPLIT_EN
  logic [N-1:0] split_mask_q;

  always_comb begin
    split_mask_d = split_mask_q;
    if (HREADY && (HRESP == RS_SPLIT) && (hmaster_q != DEF_IDX)) begin
      split_mask_d[hmaster_q] = 1'b1;
    end
    // A resume arriving in the same cycle as the SPLIT wins.
    split_mask_d = split_mask_d & ~HSPLIT;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) split_mask_q <= '0;
    else        split_mask_q <= split_mask_d;
  end
`else
  logic unused_hsplit;
  assign unused_hsplit = ^HSPLIT;
  assign split_mask_d  = '0;
`endif

  always_comb begin
    arb_point  = HREADY && ((HTRANS == TR_IDLE) ||
                            ((HTRANS == TR_NONSEQ) && ((HBURST == BU_SINGLE) || (HBURST == BU_INCR))) ||
                            ((HTRANS == TR_SEQ) && (beat_cnt_q == 4'd1)));
    resp_abort = HREADY && ((HRESP == RS_RETRY) || (HRESP == RS_SPLIT));
    lock_hold  = (state_q != ST_PARK) && HLOCK[grant_idx_q];
    eligible   = HBUSREQ & ~split_mask_d;
    winner     = (ARB_MODE == 0) ? fixed_pick(eligible) : rr_pick(eligible, last_q);
  end

  // NOTE: every variable driven here is given a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    hmaster_d   = hmaster_q;
    hmastlock_d = hmastlock_q;
    beat_cnt_d  = beat_cnt_q;
    last_d      = last_q;

    if (HREADY) begin
      case (HTRANS)
        TR_NONSEQ: beat_cnt_d = burst_beats(HBURST);
        TR_SEQ:    if (beat_cnt_q != 4'd0) beat_cnt_d = beat_cnt_q - 4'd1;
        TR_IDLE:   beat_cnt_d = 4'd0;
        default:   beat_cnt_d = beat_cnt_q;
      endcase
      if (resp_abort) beat_cnt_d = 4'd0;

      hmaster_d   = grant_idx_q;
      hmastlock_d = HLOCK[grant_idx_q];

      if (arb_point || resp_abort) begin
        if (lock_hold) begin
          state_d = ST_LOCKED;
        end else if (eligible == '0) begin
          state_d     = ST_PARK;
          grant_idx_d = DEF_IDX;
        end else begin
          state_d     = ST_OWNED;
          grant_idx_d = winner;
          last_d      = winner;
        end
      end
    end

    hgrant_d              = '0;
    hgrant_d[grant_idx_d] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= ST_PARK;
      grant_idx_q <= DEF_IDX;
      hgrant_q    <= DEF_ONEHOT;
      hmaster_q   <= DEF_IDX;
      hmastlock_q <= 1'b0;
      beat_cnt_q  <= 4'd0;
      last_q      <= DEF_IDX;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      hgrant_q    <= hgrant_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
      beat_cnt_q  <= beat_cnt_d;
      last_q      <= last_d;
    end
  end

  always_comb begin
    HGRANT    = hgrant_q;
    HMASTER   = hmaster_q;
    HMASTLOCK = hmastlock_q;
  end

endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// Scoreboard bench for ahb_arbiter_rr: a round-robin and a fixed-priority instance share one stimulus stream.
// Expectations for the SPLIT scenario follow whether AHB_ARB_SPLIT_EN is defined for the build.
module tb_ahb_arbiter_rr;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NSQ    = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;
  localparam logic [1:0] R_OK     = 2'b00;
  localparam logic [1:0] R_SPLIT  = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'b000;
  localparam logic [2:0] B_INCR   = 3'b001;
  localparam logic [2:0] B_INCR4  = 3'b011;
  localparam logic [2:0] B_WRAP8  = 3'b100;

`ifdef AHB_ARB_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] lck;
    logic [3:0] spl;
    logic [1:0] trn;
    logic [2:0] bst;
    logic       rdy;
    logic [1:0] rsp;
  } stim_t;

  typedef struct {
    logic [3:0] grant;
    logic [1:0] master;
    logic       mlock;
  } exp_t;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic [3:0] HBUSREQ, HLOCK, HSPLIT;
  logic [1:0] HTRANS, HRESP;
  logic [2:0] HBURST;
  logic       HREADY;
  logic [3:0] rr_grant, fx_grant;
  logic [1:0] rr_master, fx_master;
  logic       rr_mlock, fx_mlock;

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  always #5 HCLK = ~HCLK;

  ahb_arbiter_rr #(.NO_OF_MASTERS(4), .DEFAULT_MASTER(0), .ARB_MODE(1)) u_rr (
    .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK), .HSPLIT(HSPLIT),
    .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY), .HRESP(HRESP),
    .HGRANT(rr_grant), .HMASTER(rr_master), .HMASTLOCK(rr_mlock)
  );

  ahb_arbiter_rr #(.NO_OF_MASTERS(4), .DEFAULT_MASTER(0), .ARB_MODE(0)) u_fx (
    .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK), .HSPLIT(HSPLIT),
    .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY), .HRESP(HRESP),
    .HGRANT(fx_grant), .HMASTER(fx_master), .HMASTLOCK(fx_mlock)
  );

  function automatic stim_t mk(input logic rst, input logic [3:0] req, input logic [3:0] lck,
                               input logic [3:0] spl, input logic [1:0] trn, input logic [2:0] bst,
                               input logic rdy, input logic [1:0] rsp);
    stim_t s;
    s.rst = rst; s.req = req; s.lck = lck; s.spl = spl;
    s.trn = trn; s.bst = bst; s.rdy = rdy; s.rsp = rsp;
    return s;
  endfunction

  function automatic exp_t ex(input logic [3:0] g, input logic [1:0] m, input logic l);
    exp_t e;
    e.grant = g; e.master = m; e.mlock = l;
    return e;
  endfunction

  task automatic apply(input stim_t s);
    HRESET  = s.rst;
    HBUSREQ = s.req;
    HLOCK   = s.lck;
    HSPLIT  = s.spl;
    HTRANS  = s.trn;
    HBURST  = s.bst;
    HREADY  = s.rdy;
    HRESP   = s.rsp;
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      apply(mk(i < 2, 4'b0000, 4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OK));
      sb_q.push_back(ex(4'b0001, 2'd0, 1'b0));
      tick();
      e = sb_q.pop_front();
      n_assert += 4;
      if (rr_grant !== e.grant) begin n_fail++; $display("FAIL reset[%0d] HGRANT got %b want %b", i, rr_grant, e.grant); end
      if (rr_master !== e.master) begin n_fail++; $display("FAIL reset[%0d] HMASTER got %0d want %0d", i, rr_master, e.master); end
      if (rr_mlock !== e.mlock) begin n_fail++; $display("FAIL reset[%0d] HMASTLOCK got %b want %b", i, rr_mlock, e.mlock); end
      if (fx_grant !== e.grant) begin n_fail++; $display("FAIL reset_fixed[%0d] HGRANT got %b want %b", i, fx_grant, e.grant); end
    end
  endtask

  task automatic test_rr_fairness();
    stim_t st[$];
    exp_t  xq[$];
    exp_t  e;
    st.push_back(mk(1'b1, 4'b0000, 4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OK));
    xq.push_back(ex(4'b0001, 2'd0, 1'b0));
    for (int k = 0; k < 8; k++) begin
      st.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b0000, T_NSQ, B_SINGLE, 1'b1, R_OK));
      xq.push_back(ex(4'b0001 << ((k + 1) % 4), 2'(k % 4), 1'b0));
    end
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      sb_q.push_back(xq[i]);
      tick();
      e = sb_q.pop_front();
      n_assert += 2;
      if (rr_grant !== e.grant) begin n_fail++; $display("FAIL rr_fair[%0d] HGRANT got %b want %b", i, rr_grant, e.grant); end
      if (rr_master !== e.master) begin n_fail++; $display("FAIL rr_fair[%0d] HMASTER got %0d want %0d", i, rr_master, e.master); end
    end
  endtask

  // Master 2 runs INCR4 while master 0 requests; second pass stalls the last-beat address phase for two cycles.
  task automatic test_fixed_burst();
    stim_t st[$];
    exp_t  xq[$];
    exp_t  e;
    for (int pass = 0; pass < 2; pass++) begin
      st.push_back(mk(1'b1, 4'b0000, 4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OK)); xq.push_back(ex(4'b0001, 2'd0, 1'b0));
      st.push_back(mk(1'b0, 4'b0100, 4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OK)); xq.push_back(ex(4'b0100, 2'd0, 1'b0));
      st.push_back(mk(1'b0, 4'b0101, 4'b0000, 4'b0000, T_NSQ,  B_INCR4,  1'b1, R_OK)); xq.push_back(ex(4'b0100, 2'd2, 1'b0));
      st.push_back(mk(1'b0, 4'b0101, 4'b0000, 4'b0000, T_SEQ,  B_INCR4,  1'b1, R_OK)); xq.push_back(ex(4'b0100, 2'd2, 1'b0));
      st.push_back(mk(1'b0, 4'b0101, 4'b0000, 4'b0000, T_SEQ,  B_INCR4,  1'b1, R_OK)); xq.push_back(ex(4'b0100, 2'd2, 1'b0));
      for (int w = 0; w < 2 * pass; w++) begin
        st.push_back(mk(1'b0, 4'b0101, 4'b0000, 4'b0000, T_SEQ, B_INCR4, 1'b0, R_OK)); xq.push_back(ex(4'b0100, 2'd2, 1'b0));
      end
      st.push_back(mk(1'b0, 4'b0101, 4'b0000, 4'b0000, T_SEQ,  B_INCR4,  1'b1, R_OK)); xq.push_back(ex(4'b0001, 2'd2, 1'b0));
      st.push_back(mk(1'b0, 4'b0001, 4'b0000, 4'b0000, T_NSQ,  B_SINGLE, 1'b1, R_OK)); xq.push_back(ex(4'b0001, 2'd0, 1'b0));
    end
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      sb_q.push_back(xq[i]);
      tick();
      e = sb_q.pop_front();
      n_assert += 2;
      if (fx_grant !== e.grant) begin n_fail++; $display("FAIL fixed_burst[%0d] HGRANT got %b want %b", i, fx_grant, e.grant); end
      if (fx_master !== e.master) begin n_fail++; $display("FAIL fixed_burst[%0d] HMASTER got %0d want %0d", i, fx_master, e.master); end
    end
  endtask

  task automatic test_lock();
    stim_t st[$];
    exp_t  xq[$];
    exp_t  e;
    st.push_back(mk(1'b1, 4'b0000, 4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OK)); xq.push_back(ex(4'b0001, 2'd0, 1'b0));
    st.push_back(mk(1'b0, 4'b1111, 4'b0010, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OK)); xq.push_back(ex(4'b0010, 2'd0, 1'b0));
    for (int b = 0; b < 9; b++) begin
      st.push_back(mk(1'b0, 4'b1111, 4'b0010, 4'b0000, (b % 3 == 0) ? T_NSQ : T_SEQ, B_INCR, 1'b1, R_OK));
      xq.push_back(ex(4'b0010, 2'd1, 1'b1));
    end
    st.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b0000, T_NSQ, B_INCR, 1'b1, R_OK)); xq.push_back(ex(4'b0100, 2'd1, 1'b0));
    st.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b0000, T_SEQ, B_INCR, 1'b1, R_OK)); xq.push_back(ex(4'b0100, 2'd2, 1'b0));
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      sb_q.push_back(xq[i]);
      tick();
      e = sb_q.pop_front();
      n_assert += 3;
      if (rr_grant !== e.grant) begin n_fail++; $display("FAIL lock[%0d] HGRANT got %b want %b", i, rr_grant, e.grant); end
      if (rr_master !== e.master) begin n_fail++; $display("FAIL lock[%0d] HMASTER got %0d want %0d", i, rr_master, e.master); end
      if (rr_mlock !== e.mlock) begin n_fail++; $display("FAIL lock[%0d] HMASTLOCK got %b want %b", i, rr_mlock, e.mlock); end
    end
  endtask

  // Master 3 takes a two-cycle SPLIT; the resume pulse arrives during an HREADY=0 cycle.
  task automatic test_split();
    stim_t st[$];
    exp_t  xq[$];
    exp_t  e;
    logic [3:0] gs;
    logic [1:0] ms;
    gs = SPLIT_EN ? 4'b0001 : 4'b1000;
    ms = SPLIT_EN ? 2'd0 : 2'd3;
    st.push_back(mk(1'b1, 4'b0000, 4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OK));    xq.push_back(ex(4'b0001, 2'd0, 1'b0));
    st.push_back(mk(1'b0, 4'b1000, 4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OK));    xq.push_back(ex(4'b1000, 2'd0, 1'b0));
    st.push_back(mk(1'b0, 4'b1000, 4'b0000, 4'b0000, T_NSQ,  B_SINGLE, 1'b1, R_OK));    xq.push_back(ex(4'b1000, 2'd3, 1'b0));
    st.push_back(mk(1'b0, 4'b1000, 4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b0, R_SPLIT)); xq.push_back(ex(4'b1000, 2'd3, 1'b0));
    st.push_back(mk(1'b0, 4'b1000, 4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_SPLIT)); xq.push_back(ex(gs, 2'd3, 1'b0));
    st.push_back(mk(1'b0, 4'b1000, 4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OK));    xq.push_back(ex(gs, ms, 1'b0));
    st.push_back(mk(1'b0, 4'b1000, 4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OK));    xq.push_back(ex(gs, ms, 1'b0));
    st.push_back(mk(1'b0, 4'b1000, 4'b0000, 4'b1000, T_IDLE, B_SINGLE, 1'b0, R_OK));    xq.push_back(ex(gs, ms, 1'b0));
    st.push_back(mk(1'b0, 4'b1000, 4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OK));    xq.push_back(ex(4'b1000, ms, 1'b0));
    st.push_back(mk(1'b0, 4'b1000, 4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OK));    xq.push_back(ex(4'b1000, 2'd3, 1'b0));
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      sb_q.push_back(xq[i]);
      tick();
      e = sb_q.pop_front();
      n_assert += 2;
      if (rr_grant !== e.grant) begin n_fail++; $display("FAIL split[%0d] HGRANT got %b want %b", i, rr_grant, e.grant); end
      if (rr_master !== e.master) begin n_fail++; $display("FAIL split[%0d] HMASTER got %0d want %0d", i, rr_master, e.master); end
    end
  endtask

  // Reset lands on the WRAP8 beat-5 address phase; the following SEQ cycles must not act as a last-beat AP.
  task automatic test_mid_burst_reset();
    stim_t st[$];
    exp_t  xq[$];
    exp_t  e;
    st.push_back(mk(1'b1, 4'b0000, 4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OK)); xq.push_back(ex(4'b0001, 2'd0, 1'b0));
    st.push_back(mk(1'b0, 4'b0100, 4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OK)); xq.push_back(ex(4'b0100, 2'd0, 1'b0));
    st.push_back(mk(1'b0, 4'b0100, 4'b0000, 4'b0000, T_NSQ,  B_WRAP8,  1'b1, R_OK)); xq.push_back(ex(4'b0100, 2'd2, 1'b0));
    for (int b = 0; b < 3; b++) begin
      st.push_back(mk(1'b0, 4'b0100, 4'b0000, 4'b0000, T_SEQ, B_WRAP8, 1'b1, R_OK)); xq.push_back(ex(4'b0100, 2'd2, 1'b0));
    end
    st.push_back(mk(1'b1, 4'b0100, 4'b0000, 4'b0000, T_SEQ, B_WRAP8, 1'b1, R_OK)); xq.push_back(ex(4'b0001, 2'd0, 1'b0));
    for (int b = 0; b < 4; b++) begin
      st.push_back(mk(1'b0, 4'b0100, 4'b0000, 4'b0000, T_SEQ, B_WRAP8, 1'b1, R_OK)); xq.push_back(ex(4'b0001, 2'd0, 1'b0));
    end
    st.push_back(mk(1'b0, 4'b0100, 4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1, R_OK)); xq.push_back(ex(4'b0100, 2'd0, 1'b0));
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      sb_q.push_back(xq[i]);
      tick();
      e = sb_q.pop_front();
      n_assert += 3;
      if (rr_grant !== e.grant) begin n_fail++; $display("FAIL mid_reset[%0d] HGRANT got %b want %b", i, rr_grant, e.grant); end
      if (rr_master !== e.master) begin n_fail++; $display("FAIL mid_reset[%0d] HMASTER got %0d want %0d", i, rr_master, e.master); end
      if (rr_mlock !== e.mlock) begin n_fail++; $display("FAIL mid_reset[%0d] HMASTLOCK got %b want %b", i, rr_mlock, e.mlock); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got still-running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_rr_fairness();
    test_fixed_burst();
    test_lock();
    test_split();
    test_mid_burst_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
